// File: rtl/pwm_fade_pkg.sv
// Shared types and constants for the PWM fade sequencer: FSM states, register map, CTRL bits.
package pwm_fade_pkg;

   localparam int unsigned DATA_W  = 8;
   localparam int unsigned PRESC_W = 16;
   localparam int unsigned ADDR_W  = 4;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_UP      = 3'd1,
      ST_HOLD_HI = 3'd2,
      ST_DOWN    = 3'd3,
      ST_HOLD_LO = 3'd4
   } state_t;

   localparam logic [ADDR_W-1:0] ADDR_CTRL     = 4'h0;
   localparam logic [ADDR_W-1:0] ADDR_DUTY_MIN = 4'h1;
   localparam logic [ADDR_W-1:0] ADDR_DUTY_MAX = 4'h2;
   localparam logic [ADDR_W-1:0] ADDR_STEP     = 4'h3;
   localparam logic [ADDR_W-1:0] ADDR_PRESC_LO = 4'h4;
   localparam logic [ADDR_W-1:0] ADDR_PRESC_HI = 4'h5;
   localparam logic [ADDR_W-1:0] ADDR_HOLD     = 4'h6;
   localparam logic [ADDR_W-1:0] ADDR_DUTY     = 4'h7;
   localparam logic [ADDR_W-1:0] ADDR_STATE    = 4'h8;

   localparam int unsigned CTRL_ENABLE = 0;
   localparam int unsigned CTRL_LOOP   = 1;
   localparam int unsigned CTRL_START  = 2;
   localparam int unsigned CTRL_INVERT = 3;

   // Sequencer configuration as written by the CPU
   typedef struct packed {
      logic [DATA_W-1:0]  duty_min;
      logic [DATA_W-1:0]  duty_max;
      logic [DATA_W-1:0]  step;
      logic [PRESC_W-1:0] presc;
      logic [DATA_W-1:0]  hold;
   } cfg_t;

endpackage

// File: rtl/pwm_fade_gen.sv
// Free-running 8-bit PWM generator: period counter, wrap flag and duty comparator.
module pwm_fade_gen
   import pwm_fade_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] duty,
   input  logic              invert,
   output logic              wrap_c,
   output logic              pwm_c
);

   logic [DATA_W-1:0] cnt;
   logic              raw;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt <= '0;
      else        cnt <= cnt + DATA_W'(1);
   end

   assign wrap_c = (cnt == '1);

   // 0 and 255 are pinned so the extremes give a solid low / solid high output
   always_comb begin
      raw = 1'b0;
      if (duty == '0)      raw = 1'b0;
      else if (duty == '1) raw = 1'b1;
      else                 raw = (cnt < duty);
   end

   assign pwm_c = raw ^ invert;

endmodule

// File: rtl/tqvp_pwm_fade.sv
// TinyQV peripheral: register file, start synchronizer, prescaler and fade sequencer FSM.
module tqvp_pwm_fade
   import pwm_fade_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [7:0]        ui_in,
   output logic [7:0]        uo_out,
   input  logic [ADDR_W-1:0] address,
   input  logic              data_write,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out
);

   cfg_t               cfg;
   logic               enable;
   logic               loop_en;
   logic               invert;
   state_t             state;
   logic [DATA_W-1:0]  duty;
   logic [DATA_W-1:0]  hcnt;
   logic [PRESC_W-1:0] pcnt;
   logic               done;
   logic [2:0]         sync;

   logic               wrap_c;
   logic               pwm_c;
   logic               tick_c;
   logic               ctrl_wr_c;
   logic               en_next_c;
   logic               start_c;
   logic [DATA_W-1:0]  step_c;
   logic [DATA_W:0]    up_sum_c;
   logic [DATA_W:0]    dn_floor_c;
   logic               unused_ui;

   assign unused_ui = ^ui_in[7:1];

   pwm_fade_gen u_gen (
      .clk    (clk),
      .rst_n  (rst_n),
      .duty   (duty),
      .invert (invert),
      .wrap_c (wrap_c),
      .pwm_c  (pwm_c)
   );

   // A CTRL write decides enable in the same cycle, so a start in a disabling write is dropped
   assign ctrl_wr_c  = data_write && (address == ADDR_CTRL);
   assign en_next_c  = ctrl_wr_c ? data_in[CTRL_ENABLE] : enable;
   assign start_c    = (ctrl_wr_c && data_in[CTRL_START]) || (sync[1] && !sync[2]);
   assign tick_c     = wrap_c && (pcnt == cfg.presc);
   assign step_c     = (cfg.step == '0) ? DATA_W'(1) : cfg.step;
   assign up_sum_c   = {1'b0, duty} + {1'b0, step_c};
   assign dn_floor_c = {1'b0, cfg.duty_min} + {1'b0, step_c};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync <= '0;
      else        sync <= {sync[1:0], ui_in[0]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         enable  <= 1'b0;
         loop_en <= 1'b0;
         invert  <= 1'b0;
         cfg     <= '0;
      end else if (data_write) begin
         case (address)
            ADDR_CTRL: begin
               enable  <= data_in[CTRL_ENABLE];
               loop_en <= data_in[CTRL_LOOP];
               invert  <= data_in[CTRL_INVERT];
            end
            ADDR_DUTY_MIN: cfg.duty_min     <= data_in;
            ADDR_DUTY_MAX: cfg.duty_max     <= data_in;
            ADDR_STEP:     cfg.step         <= data_in;
            ADDR_PRESC_LO: cfg.presc[7:0]   <= data_in;
            ADDR_PRESC_HI: cfg.presc[15:8]  <= data_in;
            ADDR_HOLD:     cfg.hold         <= data_in;
            default: ;
         endcase
      end
   end

   // Sequencer: duty only moves on ticks, which coincide with the period wrap
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         duty  <= '0;
         hcnt  <= '0;
         pcnt  <= '0;
         done  <= 1'b0;
      end else if (!en_next_c) begin
         state <= ST_IDLE;
         duty  <= '0;
         pcnt  <= '0;
         done  <= 1'b0;
      end else if (start_c) begin
         state <= ST_UP;
         duty  <= cfg.duty_min;
         pcnt  <= '0;
         done  <= 1'b0;
      end else begin
         if (wrap_c) pcnt <= (pcnt == cfg.presc) ? '0 : pcnt + PRESC_W'(1);
         if (tick_c) begin
            case (state)
               ST_UP: begin
                  if (up_sum_c >= {1'b0, cfg.duty_max}) begin
                     duty  <= cfg.duty_max;
                     hcnt  <= cfg.hold;
                     state <= ST_HOLD_HI;
                  end else begin
                     duty <= up_sum_c[DATA_W-1:0];
                  end
               end
               ST_HOLD_HI: begin
                  if (hcnt == '0) state <= ST_DOWN;
                  else            hcnt  <= hcnt - DATA_W'(1);
               end
               ST_DOWN: begin
                  if ({1'b0, duty} < dn_floor_c) begin
                     duty  <= cfg.duty_min;
                     hcnt  <= cfg.hold;
                     state <= ST_HOLD_LO;
                  end else begin
                     duty <= duty - step_c;
                  end
               end
               ST_HOLD_LO: begin
                  if (hcnt == '0) begin
                     if (loop_en) begin
                        state <= ST_UP;
                     end else begin
                        state <= ST_IDLE;
                        done  <= 1'b1;
                     end
                  end else begin
                     hcnt <= hcnt - DATA_W'(1);
                  end
               end
               ST_IDLE: ;
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

   assign uo_out = {4'b0000, done, (state != ST_IDLE), tick_c, pwm_c};

   always_comb begin
      data_out = '0;
      case (address)
         ADDR_CTRL:     data_out = {4'b0000, invert, 1'b0, loop_en, enable};
         ADDR_DUTY_MIN: data_out = cfg.duty_min;
         ADDR_DUTY_MAX: data_out = cfg.duty_max;
         ADDR_STEP:     data_out = cfg.step;
         ADDR_PRESC_LO: data_out = cfg.presc[7:0];
         ADDR_PRESC_HI: data_out = cfg.presc[15:8];
         ADDR_HOLD:     data_out = cfg.hold;
         ADDR_DUTY:     data_out = duty;
         ADDR_STATE:    data_out = {5'b00000, state};
         default:       data_out = '0;
      endcase
   end

endmodule

// File: tb/tb_tqvp_pwm_fade.sv
// Directed bench for tqvp_pwm_fade with hand-computed duty/state sequences.
module tb_tqvp_pwm_fade;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] ui_in;
   logic [7:0] uo_out;
   logic [3:0] address;
   logic       data_write;
   logic [7:0] data_in;
   logic [7:0] data_out;

   int n_checks = 0;
   int n_pass   = 0;

   tqvp_pwm_fade dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ui_in      (ui_in),
      .uo_out     (uo_out),
      .address    (address),
      .data_write (data_write),
      .data_in    (data_in),
      .data_out   (data_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Called at a negedge; returns at the negedge after the write edge
   task automatic wr(input logic [3:0] a, input logic [7:0] d);
      address    = a;
      data_in    = d;
      data_write = 1'b1;
      @(posedge clk);
      @(negedge clk);
      data_write = 1'b0;
   endtask

   task automatic rd(input logic [3:0] a, output logic [7:0] d);
      address = a;
      #1;
      d = data_out;
   endtask

   task automatic check_ds(input string tag, input logic [7:0] exp_duty, input logic [7:0] exp_state);
      logic [7:0] v;
      rd(4'h7, v);
      check({tag, "_duty"}, v, exp_duty);
      rd(4'h8, v);
      check({tag, "_state"}, v, exp_state);
   endtask

   // Waits for a tick pulse, then steps to the negedge after the update edge
   task automatic wait_tick(output int waited);
      waited = 0;
      while (!uo_out[1] && waited < 1000) begin
         @(negedge clk);
         waited++;
      end
      check("tick_seen", uo_out[1], 1);
      @(negedge clk);
   endtask

   task automatic count_pwm(output int hi);
      hi = 0;
      for (int i = 0; i < 256; i++) begin
         hi += int'(uo_out[0]);
         @(negedge clk);
      end
   endtask

   logic [7:0] v;
   int         w;
   int         hi;
   logic [7:0] os_duty  [9] = '{8'h20, 8'h30, 8'h40, 8'h40, 8'h30, 8'h20, 8'h10, 8'h10, 8'h10};
   logic [7:0] os_state [9] = '{8'd1, 8'd1, 8'd2, 8'd3, 8'd3, 8'd3, 8'd3, 8'd4, 8'd0};
   logic [7:0] lp_duty  [16] = '{8'h20, 8'h30, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h30,
                                 8'h20, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h20};
   logic [7:0] lp_state [16] = '{8'd1, 8'd1, 8'd2, 8'd2, 8'd2, 8'd2, 8'd3, 8'd3,
                                 8'd3, 8'd3, 8'd4, 8'd4, 8'd4, 8'd4, 8'd1, 8'd1};

   initial begin
      rst_n      = 1'b0;
      ui_in      = 8'h00;
      address    = 4'h0;
      data_write = 1'b0;
      data_in    = 8'h00;
      repeat (3) @(negedge clk);
      check("rst_uo", uo_out, 8'h00);
      rst_n = 1'b1;
      @(negedge clk);

      // Reset state: registers read 0, outputs 0, counter wraps every 256 clk
      for (int a = 0; a < 10; a++) begin
         rd(4'(a), v);
         check($sformatf("rst_reg%0d", a), v, 8'h00);
      end
      check("rst_uo2", uo_out, 8'h00);
      wait_tick(w);
      wait_tick(w);
      check("idle_tick_gap", w + 1, 256);

      // One-shot run
      wr(4'h1, 8'h10);
      wr(4'h2, 8'h40);
      wr(4'h3, 8'h10);
      wr(4'h0, 8'h05);
      check_ds("os_start", 8'h10, 8'd1);
      check("os_busy", uo_out[2], 1);
      rd(4'h0, v);
      check("ctrl_rd", v, 8'h01);
      rd(4'h3, v);
      check("step_rd", v, 8'h10);
      for (int i = 0; i < 9; i++) begin
         wait_tick(w);
         check_ds($sformatf("os_t%0d", i + 1), os_duty[i], os_state[i]);
      end
      check("os_done", uo_out[3], 1);
      check("os_busy_end", uo_out[2], 0);
      count_pwm(hi);
      check("os_pwm_hi", hi, 16);

      // Saturation near the top; the new start also clears done
      wr(4'h1, 8'hC0);
      wr(4'h2, 8'hFA);
      wr(4'h3, 8'h30);
      wr(4'h0, 8'h05);
      check("sat_done_clr", uo_out[3], 0);
      check_ds("sat_start", 8'hC0, 8'd1);
      wait_tick(w);
      check_ds("sat_t1", 8'hF0, 8'd1);
      wait_tick(w);
      check_ds("sat_t2", 8'hFA, 8'd2);

      // DOWN floor clamp: duty 0x0A, MIN lowered to 0x05 mid-run, STEP 0x10
      wr(4'h1, 8'h0A);
      wr(4'h2, 8'h0A);
      wr(4'h3, 8'h10);
      wr(4'h0, 8'h05);
      wait_tick(w);
      check_ds("dn_t1", 8'h0A, 8'd2);
      wait_tick(w);
      check_ds("dn_t2", 8'h0A, 8'd3);
      wr(4'h1, 8'h05);
      wait_tick(w);
      check_ds("dn_t3", 8'h05, 8'd4);

      // Boundaries at the duty extremes, with and without invert
      wr(4'h1, 8'hFF);
      wr(4'h2, 8'hFF);
      wr(4'h0, 8'h05);
      count_pwm(hi);
      check("pwm_ff", hi, 256);
      wr(4'h0, 8'h0D);
      rd(4'h0, v);
      check("ctrl_inv_rd", v, 8'h09);
      count_pwm(hi);
      check("pwm_ff_inv", hi, 0);
      wr(4'h1, 8'h00);
      wr(4'h2, 8'h00);
      wr(4'h0, 8'h05);
      count_pwm(hi);
      check("pwm_00", hi, 0);
      wr(4'h0, 8'h0D);
      count_pwm(hi);
      check("pwm_00_inv", hi, 256);

      // Restart mid-DOWN
      wr(4'h0, 8'h01);
      wr(4'h1, 8'h10);
      wr(4'h2, 8'h40);
      wr(4'h0, 8'h05);
      for (int i = 0; i < 5; i++) wait_tick(w);
      check_ds("rs_mid", 8'h30, 8'd3);
      wr(4'h0, 8'h05);
      check_ds("rs_restart", 8'h10, 8'd1);
      check("rs_done", uo_out[3], 0);

      // Disable, with a start in the same write
      wr(4'h0, 8'h04);
      check_ds("dis", 8'h00, 8'd0);
      check("dis_busy", uo_out[2], 0);
      wait_tick(w);
      check_ds("dis_stay", 8'h00, 8'd0);

      // Async reset mid-run
      wr(4'h0, 8'h05);
      wait_tick(w);
      wait_tick(w);
      check("ar_pwm_pre", uo_out[0], 1);
      #1 rst_n = 1'b0;
      #1;
      check("ar_uo", uo_out, 8'h00);
      rd(4'h1, v);
      check("ar_min", v, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Prescaler 2, hold 3, looping
      wr(4'h1, 8'h10);
      wr(4'h2, 8'h40);
      wr(4'h3, 8'h10);
      wr(4'h4, 8'h02);
      wr(4'h6, 8'h03);
      wr(4'h0, 8'h07);
      for (int i = 0; i < 16; i++) begin
         wait_tick(w);
         if (i > 0) check($sformatf("lp_gap%0d", i + 1), w + 1, 768);
         check_ds($sformatf("lp_t%0d", i + 1), lp_duty[i], lp_state[i]);
         check($sformatf("lp_done%0d", i + 1), uo_out[3], 0);
      end

      // External start via ui_in[0]
      wr(4'h0, 8'h00);
      wr(4'h0, 8'h01);
      ui_in = 8'h01;
      @(negedge clk);
      check_ds("ext_c1", 8'h00, 8'd0);
      @(negedge clk);
      check_ds("ext_c2", 8'h00, 8'd0);
      @(negedge clk);
      check_ds("ext_c3", 8'h10, 8'd1);
      ui_in = 8'h00;
      repeat (4) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/tqvp_pwm_fade.md
# tqvp_pwm_fade

Autonomous PWM fade sequencer peripheral on the TinyQV 8-bit peripheral bus. It owns a free-running 8-bit PWM generator and sequences its duty cycle through ramp-up, hold-high, ramp-down and hold-low phases, either once or looping. Ramp step, limits, prescaler and hold time are set through registers. The CPU only configures and starts the sequence; it does not need to write duty values per period.

## Interface
- Parameters: none; all widths fixed at 8 bits, except the 16-bit prescaler.
- Ports:
  - clk  in  1  system clock
  - rst_n  in  1  reset, asynchronous, active-low
  - ui_in  in  8  bit0 = external start trigger (asynchronous); others unused
  - uo_out  out  8  [0] pwm, [1] tick pulse, [2] busy, [3] done, [7:4] = 0
  - address  in  4  register select
  - data_write  in  1  one-cycle write strobe
  - data_in  in  8  write data
  - data_out  out  8  combinational read data

## Operation
- Registers (R/W unless noted; reset 0):
  - 0x0 CTRL: [0] enable, [1] loop, [2] start (write-1 strobe, reads 0), [3] invert.
  - 0x1 DUTY_MIN, 0x2 DUTY_MAX, 0x3 STEP (0 behaves as 1).
  - 0x4 PRESC_LO, 0x5 PRESC_HI, 0x6 HOLD.
  - 0x7 DUTY (RO, current duty), 0x8 STATE (RO, {5'b0, state}).
  - Other addresses read 0; writes to them are ignored.
- PWM counter `cnt`: free-running 8-bit, increments every clk, never gated.
- pwm = (duty==0) ? 0 : (duty==255) ? 1 : (cnt < duty), then XOR invert.
- Period wrap: `cnt`==255.
- Prescaler `pcnt` (16b): increments at each wrap. When `pcnt`==PRESC at a wrap, `tick` is high for that cycle and `pcnt` clears.
- States (3-bit): IDLE=0, UP=1, HOLD_HI=2, DOWN=3, HOLD_LO=4.
- Start source: CTRL write with bit2=1, or rising edge of ui_in[0] after a 2-flop synchronizer.
- On start with enable=1 (including while busy):
  - duty <= DUTY_MIN, `pcnt` <= 0, done <= 0, state <= UP.
- Actions on tick, per state:
  - UP: sum = duty+STEP as a 9-bit value. If sum ≥ DUTY_MAX, duty <= DUTY_MAX, hcnt <= HOLD, state <= HOLD_HI; otherwise duty <= sum.
  - HOLD_HI: if hcnt==0, go to DOWN; otherwise hcnt--.
  - DOWN: if duty < DUTY_MIN+STEP (9-bit compare), duty <= DUTY_MIN, hcnt <= HOLD, state <= HOLD_LO; otherwise duty -= STEP.
  - HOLD_LO: if hcnt==0, then loop ? UP : (IDLE, done <= 1); otherwise hcnt--.
- A hold phase lasts HOLD+1 ticks.
- If DUTY_MIN ≥ DUTY_MAX, UP exits on the first tick with duty=DUTY_MAX. This is legal and must not wrap.
- enable=0: state <= IDLE immediately, duty <= 0, `pcnt` <= 0. A start is ignored while enable=0, including a start in the same write that clears enable.
- IDLE keeps the last duty; the PWM keeps running at that duty.
- Config writes during a run take effect at the next tick's comparisons.
- done is sticky until the next start or until enable=0.
- busy = (state != IDLE).

## Timing
- Reset: all registers, `cnt`, `pcnt`, hcnt and duty are 0; state is IDLE; uo_out = 0x00.
- CTRL start write in cycle N:
  - state=UP and duty=DUTY_MIN visible in cycle N+1.
  - busy=1 in cycle N+1.
- ui_in[0] start: 3-cycle latency from pin edge to the state change.
- Tick-driven duty updates register at the wrap edge. The new duty governs the pwm from `cnt`==0, so there are no partial-period glitches.
- Tick spacing = 256·(PRESC+1) clk.
- uo_out[1] is high for exactly the wrap cycle of a tick.
- data_out is combinational from address; reads have no side effects.

## Structure
- Package pwm_fade_pkg:
  - state enum
  - register address constants
  - CTRL bit indices
- One sub-module, pwm_fade_gen: `cnt`, the wrap output and the duty comparator (including the 0/255 rules and invert).
- The top level holds the register file, synchronizer, prescaler and FSM.

## Test plan
- Reset, then read all registers → 0; uo_out=0x00; `cnt` counting.
- One-shot run:
  - Setup: MIN=0x10, MAX=0x40, STEP=0x10, PRESC=0, HOLD=0, CTRL=0x05.
  - Required duty per tick: 0x20, 0x30, 0x40, (hold), 0x30, 0x20, 0x10, (hold).
  - Then IDLE with done=1 and busy=0.
  - pwm high count per period matches duty.
- Saturation:
  - MAX=0xFA, STEP=0x30 from MIN=0xC0 → 0xF0, 0xFA; no wrap.
  - DOWN with MIN=0x05, STEP=0x10 from duty 0x0A → 0x05.
- Boundaries:
  - MIN=MAX=0xFF → pwm constant 1.
  - MIN=MAX=0x00 → pwm constant 0.
  - invert=1 flips both.
- Restart and disable:
  - Start mid-DOWN → duty=MIN in the next cycle, done=0.
  - Write CTRL=0x04 (enable=0) → stays IDLE and duty=0.
  - Async reset asserted mid-run → uo_out=0 immediately.
- Prescaler, hold and loop:
  - PRESC=0x0002, HOLD=3, loop=1 → tick every 768 clk; each hold lasts 4 ticks; sequence repeats and done is never set.
  - ui_in[0] pulse starts a run after 3 cycles.
